cla_serial_adder: RTL and testbench

//   Multi-precision adder that drives a single cla_4b instance one nibble per cycle.

---
 rtl/cla_serial_adder.sv | 151 +++++++++++++++
 tb/tb_cla_serial_adder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_serial_adder.sv
// Nibble-serial multi-precision adder: one 4-bit carry-lookahead slice reused
// across WIDTH/4 cycles, with valid/ready handshakes on operands and result.

module cla_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);
        sum   = p ^ c[3:0];
        c_out = c[4];
    end
endmodule

module cla_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;

    logic [3:0]         cla_sum;
    logic               cla_c_out;
    logic [WIDTH+3:0]   sum_cat;
    logic               last_nib;

    cla_4b u_cla (
        .a     (a_sh_q[3:0]),
        .b     (b_sh_q[3:0]),
        .c_in  (carry_q),
        .sum   (cla_sum),
        .c_out (cla_c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    // Operand shifters hold pure data and need no reset.
    always_ff @(posedge clk) begin
        a_sh_q <= a_sh_d;
        b_sh_q <= b_sh_d;
    end

    always_comb begin
        last_nib = (cnt_q == CNT_W'(NIB - 1));
        state_d  = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_nib)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        // New nibble enters at the top so the LSB nibble ends up at bit 0.
        sum_cat = {cla_sum, sum_q};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = c_in;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                sum_d   = sum_cat[WIDTH+3:4];
                carry_d = cla_c_out;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        c_out     = carry_q;
        ovf       = (a_msb_q == b_msb_q) && (sum_q[WIDTH-1] != a_msb_q);
    end
endmodule

// File: tb/tb_cla_serial_adder.sv
// Bench for cla_serial_adder: 16-bit instance against an arithmetic reference
// model plus directed cases, and an exhaustive sweep of a 4-bit instance.

module tb_cla_serial_adder;
    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf;
    logic [15:0] a, b, sum;

    logic        in_valid4, in_ready4, c_in4, out_valid4, out_ready4, c_out4, ovf4;
    logic [3:0]  a4, b4, sum4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cla_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    cla_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .c_in(c_in4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .c_out(c_out4), .ovf(ovf4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result as {ovf, c_out, sum}: unsigned sum for carry, signed sum for overflow.
    function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        int su, ss;
        logic [17:0] r;
        su = int'(x) + int'(y) + int'(ci);
        ss = int'($signed(x)) + int'($signed(y)) + int'(ci);
        r[15:0] = su[15:0];
        r[16]   = su[16];
        r[17]   = (ss > 32767) || (ss < -32768);
        return r;
    endfunction

    function automatic logic [5:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        int su, ss;
        logic [5:0] r;
        su = int'(x) + int'(y) + int'(ci);
        ss = int'($signed(x)) + int'($signed(y)) + int'(ci);
        r[3:0] = su[3:0];
        r[4]   = su[4];
        r[5]   = (ss > 7) || (ss < -8);
        return r;
    endfunction

    // Cycle-level compare process for the 16-bit instance.
    int          cyc = 0;
    bit          pend = 1'b0;
    int          rdy_cyc = 0;
    logic [17:0] exp_r;
    always @(negedge clk) begin
        bit ev;
        cyc++;
        if (!rst_n) begin
            pend = 1'b0;
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_sum", {16'd0, sum}, 32'd0);
        end else begin
            ev = pend && (cyc >= rdy_cyc);
            chk("mon_in_ready", {31'd0, in_ready}, {31'd0, !pend});
            chk("mon_out_valid", {31'd0, out_valid}, {31'd0, ev});
            if (ev) begin
                chk("mon_sum", {16'd0, sum}, {16'd0, exp_r[15:0]});
                chk("mon_c_out", {31'd0, c_out}, {31'd0, exp_r[16]});
                chk("mon_ovf", {31'd0, ovf}, {31'd0, exp_r[17]});
            end
            if (ev && out_ready) begin
                pend = 1'b0;
            end else if (!pend && in_valid) begin
                pend    = 1'b1;
                rdy_cyc = cyc + 1 + NIB;
                exp_r   = ref16(a, b, c_in);
            end
        end
    end

    // Called at posedge+2 with the DUT idle; returns at posedge+2 with the result showing.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                          input logic [15:0] es, input logic ec, input logic eo);
        int n;
        a = x; b = y; c_in = ci; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 40);
        chk("latency", n, NIB);
        chk("lit_sum", {16'd0, sum}, {16'd0, es});
        chk("lit_c_out", {31'd0, c_out}, {31'd0, ec});
        chk("lit_ovf", {31'd0, ovf}, {31'd0, eo});
        #1;
    endtask

    task automatic finish_op();
        @(posedge clk); #1;
        chk("handoff_in_ready", {31'd0, in_ready}, 32'd1);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        logic [5:0] r4;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; c_in4 = 1'b0; out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid4", {31'd0, out_valid4}, 32'd0);
        chk("reset_in_ready4", {31'd0, in_ready4}, 32'd1);
        chk("reset_c_out", {31'd0, c_out}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #2;

        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0); finish_op();
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); finish_op();
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1); finish_op();
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1); finish_op();
        run_op(16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0); finish_op();

        // Consumer stall: result must hold and a stray in_valid must be ignored.
        out_ready = 1'b0;
        run_op(16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin a = 16'hABCD; b = 16'h1234; in_valid = 1'b1; end
            if (i == 3) in_valid = 1'b0;
            @(posedge clk); #1;
            chk("hold_sum", {16'd0, sum}, 32'h3334);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        #1;
        run_op(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0); finish_op();

        // Asynchronous abort during the second RUN cycle.
        a = 16'h5A5A; b = 16'hA5A5; c_in = 1'b1; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (NIB + 2) @(posedge clk);
        #1;
        chk("abort_no_result", {31'd0, out_valid}, 32'd0);
        #1;
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0); finish_op();

        // Random traffic with random back-pressure; the compare process checks it.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            a         = pick();
            b         = pick();
            c_in      = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_idle", {31'd0, in_ready}, 32'd1);

        // WIDTH=4: one RUN cycle; literal case first, then every operand pair.
        for (int t = -1; t < 512; t++) begin
            if (t < 0) begin a4 = 4'hF; b4 = 4'h0; c_in4 = 1'b1; end
            else begin a4 = 4'(t >> 5); b4 = 4'(t >> 1); c_in4 = 1'(t); end
            r4 = ref4(a4, b4, c_in4);
            in_valid4 = 1'b1;
            @(posedge clk); #2;
            in_valid4 = 1'b0;
            chk("w4_running", {31'd0, out_valid4}, 32'd0);
            @(posedge clk); #1;
            chk("w4_out_valid", {31'd0, out_valid4}, 32'd1);
            chk("w4_in_ready", {31'd0, in_ready4}, 32'd0);
            if (t < 0) begin
                chk("w4_lit_sum", {28'd0, sum4}, 32'd0);
                chk("w4_lit_c_out", {31'd0, c_out4}, 32'd1);
            end
            chk("w4_sum", {28'd0, sum4}, {28'd0, r4[3:0]});
            chk("w4_c_out", {31'd0, c_out4}, {31'd0, r4[4]});
            chk("w4_ovf", {31'd0, ovf4}, {31'd0, r4[5]});
            @(posedge clk); #1;
            chk("w4_idle", {31'd0, in_ready4}, 32'd1);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
